// File: rtl/mastermind_turn_ctrl.sv
// Mastermind turn controller and guess scorer.
// Scores each legal guess against the latched secret using per-colour histograms,
// counts turns toward WIN/LOSE and pulses next_turn to reload the turn timer.
module mastermind_turn_ctrl #(
    parameter int unsigned PEGS       = 4,
    parameter int unsigned COLOR_W    = 3,
    parameter int unsigned NUM_COLORS = 6,
    parameter int unsigned MAX_TURNS  = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [PEGS*COLOR_W-1:0] secret,
    input  logic                    submit,
    input  logic [PEGS*COLOR_W-1:0] guess,
    input  logic                    timeout,
    output logic                    next_turn,
    output logic [3:0]              turn_num,
    output logic [2:0]              black,
    output logic [2:0]              white,
    output logic                    result_valid,
    output logic                    timed_out,
    output logic                    reject,
    output logic                    busy,
    output logic                    game_over,
    output logic                    win
);

    localparam int unsigned CODE_W  = PEGS * COLOR_W;
    localparam int unsigned CNT_W   = 3;
    localparam int unsigned IDX_MAX = (PEGS > NUM_COLORS) ? PEGS : NUM_COLORS;
    localparam int unsigned IDX_W   = (IDX_MAX > 1) ? $clog2(IDX_MAX) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StPlay,
        StScoreA,
        StScoreB,
        StReport,
        StWin,
        StLose
    } state_e;

    state_e             state_q, state_d;
    logic [CODE_W-1:0]  secret_q, secret_d;
    logic [CODE_W-1:0]  guess_q, guess_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   hg_q [NUM_COLORS];
    logic [CNT_W-1:0]   hg_d [NUM_COLORS];
    logic [CNT_W-1:0]   hs_q [NUM_COLORS];
    logic [CNT_W-1:0]   hs_d [NUM_COLORS];
    logic [CNT_W-1:0]   bacc_q, bacc_d;
    logic [CNT_W-1:0]   m_q, m_d;
    logic [3:0]         turn_q, turn_d;
    logic [2:0]         black_q, black_d;
    logic [2:0]         white_q, white_d;
    logic               timed_out_q, timed_out_d;
    logic               next_turn_q, next_turn_d;
    logic               result_valid_q, result_valid_d;
    logic               reject_q, reject_d;
    logic               busy_q, busy_d;
    logic               game_over_q, game_over_d;
    logic               win_q, win_d;

    logic               illegal;
    logic [COLOR_W-1:0] g_peg, s_peg;
    logic [CNT_W-1:0]   hg_c, hs_c, hmin, m_sum;

    // Flag any peg of the incoming guess that is outside the legal colour range.
    always_comb begin
        illegal = 1'b0;
        for (int p = 0; p < PEGS; p++) begin
            if ({1'b0, guess[p*COLOR_W +: COLOR_W]} >= (COLOR_W+1)'(NUM_COLORS)) begin
                illegal = 1'b1;
            end
        end
    end

    // Select the peg pair and histogram pair addressed by the scoring index.
    always_comb begin
        g_peg = '0;
        s_peg = '0;
        hg_c  = '0;
        hs_c  = '0;
        for (int p = 0; p < PEGS; p++) begin
            if (idx_q == IDX_W'(p)) begin
                g_peg = guess_q[p*COLOR_W +: COLOR_W];
                s_peg = secret_q[p*COLOR_W +: COLOR_W];
            end
        end
        for (int c = 0; c < NUM_COLORS; c++) begin
            if (idx_q == IDX_W'(c)) begin
                hg_c = hg_q[c];
                hs_c = hs_q[c];
            end
        end
        hmin  = (hg_c < hs_c) ? hg_c : hs_c;
        m_sum = m_q + hmin;
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        secret_d    = secret_q;
        guess_d     = guess_q;
        idx_d       = idx_q;
        hg_d        = hg_q;
        hs_d        = hs_q;
        bacc_d      = bacc_q;
        m_d         = m_q;
        turn_d      = turn_q;
        black_d     = black_q;
        white_d     = white_q;
        timed_out_d = timed_out_q;
        next_turn_d = 1'b0;
        reject_d    = 1'b0;

        unique case (state_q)
            StIdle, StWin, StLose: begin
                if (start) begin
                    secret_d    = secret;
                    state_d     = StPlay;
                    turn_d      = 4'd1;
                    next_turn_d = 1'b1;
                    black_d     = '0;
                    white_d     = '0;
                    timed_out_d = 1'b0;
                end
            end
            StPlay: begin
                if (submit && !illegal) begin
                    // Submit beats a coincident timeout.
                    guess_d = guess;
                    state_d = StScoreA;
                    idx_d   = '0;
                    bacc_d  = '0;
                    m_d     = '0;
                    for (int c = 0; c < NUM_COLORS; c++) begin
                        hg_d[c] = '0;
                        hs_d[c] = '0;
                    end
                end else begin
                    if (submit) begin
                        reject_d = 1'b1;
                    end
                    // An illegal guess arriving with the timeout falls through to here.
                    if (timeout) begin
                        state_d     = StReport;
                        black_d     = '0;
                        white_d     = '0;
                        timed_out_d = 1'b1;
                    end
                end
            end
            StScoreA: begin
                if (g_peg == s_peg) begin
                    bacc_d = bacc_q + 1'b1;
                end
                for (int c = 0; c < NUM_COLORS; c++) begin
                    if (g_peg == COLOR_W'(c)) begin
                        hg_d[c] = hg_q[c] + 1'b1;
                    end
                    if (s_peg == COLOR_W'(c)) begin
                        hs_d[c] = hs_q[c] + 1'b1;
                    end
                end
                if (idx_q == IDX_W'(PEGS - 1)) begin
                    idx_d   = '0;
                    state_d = StScoreB;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StScoreB: begin
                m_d = m_sum;
                if (idx_q == IDX_W'(NUM_COLORS - 1)) begin
                    idx_d       = '0;
                    state_d     = StReport;
                    black_d     = bacc_q;
                    white_d     = m_sum - bacc_q;
                    timed_out_d = 1'b0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StReport: begin
                if (black_q == 3'(PEGS)) begin
                    state_d = StWin;
                end else if (turn_q == 4'(MAX_TURNS)) begin
                    state_d = StLose;
                end else begin
                    state_d     = StPlay;
                    turn_d      = turn_q + 4'd1;
                    next_turn_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Status flags are registered from the upcoming state so they align with it.
        result_valid_d = (state_d == StReport);
        busy_d         = (state_d == StScoreA) || (state_d == StScoreB) || (state_d == StReport);
        game_over_d    = (state_d == StWin) || (state_d == StLose);
        win_d          = (state_d == StWin);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StIdle;
            secret_q       <= '0;
            guess_q        <= '0;
            idx_q          <= '0;
            for (int c = 0; c < NUM_COLORS; c++) begin
                hg_q[c] <= '0;
                hs_q[c] <= '0;
            end
            bacc_q         <= '0;
            m_q            <= '0;
            turn_q         <= '0;
            black_q        <= '0;
            white_q        <= '0;
            timed_out_q    <= 1'b0;
            next_turn_q    <= 1'b0;
            result_valid_q <= 1'b0;
            reject_q       <= 1'b0;
            busy_q         <= 1'b0;
            game_over_q    <= 1'b0;
            win_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            secret_q       <= secret_d;
            guess_q        <= guess_d;
            idx_q          <= idx_d;
            hg_q           <= hg_d;
            hs_q           <= hs_d;
            bacc_q         <= bacc_d;
            m_q            <= m_d;
            turn_q         <= turn_d;
            black_q        <= black_d;
            white_q        <= white_d;
            timed_out_q    <= timed_out_d;
            next_turn_q    <= next_turn_d;
            result_valid_q <= result_valid_d;
            reject_q       <= reject_d;
            busy_q         <= busy_d;
            game_over_q    <= game_over_d;
            win_q          <= win_d;
        end
    end

    assign next_turn    = next_turn_q;
    assign turn_num     = turn_q;
    assign black        = black_q;
    assign white        = white_q;
    assign result_valid = result_valid_q;
    assign timed_out    = timed_out_q;
    assign reject       = reject_q;
    assign busy         = busy_q;
    assign game_over    = game_over_q;
    assign win          = win_q;

endmodule

// File: tb/tb_mastermind_turn_ctrl.sv
// Directed, table-driven bench for mastermind_turn_ctrl with default parameters.
module tb_mastermind_turn_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [11:0] secret = '0;
    logic        submit = 1'b0;
    logic [11:0] guess = '0;
    logic        timeout = 1'b0;
    logic        next_turn;
    logic [3:0]  turn_num;
    logic [2:0]  black;
    logic [2:0]  white;
    logic        result_valid;
    logic        timed_out;
    logic        reject;
    logic        busy;
    logic        game_over;
    logic        win;

    int total = 0;
    int bad   = 0;

    mastermind_turn_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .secret       (secret),
        .submit       (submit),
        .guess        (guess),
        .timeout      (timeout),
        .next_turn    (next_turn),
        .turn_num     (turn_num),
        .black        (black),
        .white        (white),
        .result_valid (result_valid),
        .timed_out    (timed_out),
        .reject       (reject),
        .busy         (busy),
        .game_over    (game_over),
        .win          (win)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic [11:0] sec;
        logic [11:0] gs;
        int          b;
        int          w;
    } vec_t;

    vec_t vecs [7];

    function automatic logic [11:0] pk(input int a, input int b, input int c, input int d);
        logic [2:0] pa, pb, pc, pd;
        pa = a[2:0];
        pb = b[2:0];
        pc = c[2:0];
        pd = d[2:0];
        return {pd, pc, pb, pa};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        submit = 1'b0;
        timeout = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic start_game(input logic [11:0] s);
        start = 1'b1;
        secret = s;
        step();
        start = 1'b0;
        check("start_next_turn", next_turn, 1);
        check("start_turn_num", turn_num, 1);
    endtask

    // Submit a guess; optionally assert timeout together with it or at cycle offset to_at.
    // Returns the cycle offset at which result_valid was seen.
    task automatic submit_guess(input logic [11:0] g, input logic to_same, input int to_at,
                                output int lat);
        int nbusy;
        nbusy = 0;
        submit = 1'b1;
        guess = g;
        timeout = to_same;
        step();
        submit = 1'b0;
        timeout = 1'b0;
        lat = 1;
        if (!busy) nbusy++;
        while (!result_valid && lat < 40) begin
            if (lat == to_at) timeout = 1'b1;
            step();
            timeout = 1'b0;
            lat++;
            if (!busy) nbusy++;
        end
        check("busy_through_score", nbusy, 0);
    endtask

    initial begin
        int lat;
        int seen;

        vecs[0] = '{sec: pk(0, 1, 2, 3), gs: pk(3, 2, 1, 0), b: 0, w: 4};
        vecs[1] = '{sec: pk(1, 1, 2, 2), gs: pk(1, 2, 1, 5), b: 1, w: 2};
        vecs[2] = '{sec: pk(0, 1, 2, 3), gs: pk(0, 1, 3, 2), b: 2, w: 2};
        vecs[3] = '{sec: pk(5, 5, 5, 5), gs: pk(0, 1, 2, 3), b: 0, w: 0};
        vecs[4] = '{sec: pk(4, 0, 4, 0), gs: pk(0, 4, 0, 4), b: 0, w: 4};
        vecs[5] = '{sec: pk(2, 3, 4, 5), gs: pk(2, 3, 4, 5), b: 4, w: 0};
        vecs[6] = '{sec: pk(0, 0, 1, 1), gs: pk(0, 1, 1, 1), b: 3, w: 0};

        // Reset state
        step();
        do_reset();
        check("rst_turn_num", turn_num, 0);
        check("rst_next_turn", next_turn, 0);
        check("rst_busy", busy, 0);
        check("rst_game_over", game_over, 0);
        check("rst_result_valid", result_valid, 0);
        check("rst_black", black, 0);

        // Table of scored guesses, each from a fresh game on turn 1
        for (int i = 0; i < 7; i++) begin
            do_reset();
            start_game(vecs[i].sec);
            submit_guess(vecs[i].gs, 1'b0, 0, lat);
            check($sformatf("vec%0d_latency", i), lat, 11);
            check($sformatf("vec%0d_valid", i), result_valid, 1);
            check($sformatf("vec%0d_black", i), black, vecs[i].b);
            check($sformatf("vec%0d_white", i), white, vecs[i].w);
            check($sformatf("vec%0d_timed_out", i), timed_out, 0);
            step();
            check($sformatf("vec%0d_valid_drop", i), result_valid, 0);
            check($sformatf("vec%0d_black_hold", i), black, vecs[i].b);
            if (vecs[i].b == 4) begin
                check($sformatf("vec%0d_win", i), win, 1);
                check($sformatf("vec%0d_next_turn", i), next_turn, 0);
            end else begin
                check($sformatf("vec%0d_next_turn", i), next_turn, 1);
                check($sformatf("vec%0d_turn_num", i), turn_num, 2);
            end
        end

        // Win on turn 2
        do_reset();
        start_game(pk(0, 1, 2, 3));
        submit_guess(pk(0, 1, 3, 2), 1'b0, 0, lat);
        check("w_t1_black", black, 2);
        check("w_t1_white", white, 2);
        step();
        check("w_t2_turn", turn_num, 2);
        submit_guess(pk(0, 1, 2, 3), 1'b0, 0, lat);
        check("w_t2_latency", lat, 11);
        check("w_t2_black", black, 4);
        check("w_t2_white", white, 0);
        step();
        check("w_game_over", game_over, 1);
        check("w_win", win, 1);
        check("w_turn_num", turn_num, 2);
        check("w_next_turn", next_turn, 0);
        check("w_busy", busy, 0);

        // Ten timeouts lead to LOSE, then restart
        do_reset();
        start_game(pk(0, 1, 2, 3));
        for (int t = 1; t <= 10; t++) begin
            timeout = 1'b1;
            step();
            timeout = 1'b0;
            check($sformatf("to%0d_valid", t), result_valid, 1);
            check($sformatf("to%0d_timed_out", t), timed_out, 1);
            check($sformatf("to%0d_bw", t), {black, white}, 0);
            check($sformatf("to%0d_turn", t), turn_num, t);
            step();
            if (t < 10) begin
                check($sformatf("to%0d_next_turn", t), next_turn, 1);
                check($sformatf("to%0d_turn_next", t), turn_num, t + 1);
            end
        end
        check("lose_game_over", game_over, 1);
        check("lose_win", win, 0);
        check("lose_turn", turn_num, 10);
        check("lose_next_turn", next_turn, 0);
        step();
        check("lose_hold", game_over, 1);
        start_game(pk(1, 1, 1, 1));
        check("restart_game_over", game_over, 0);
        check("restart_timed_out", timed_out, 0);
        step();
        check("restart_single_pulse", next_turn, 0);

        // Illegal guess: reject, turn not consumed, no result
        do_reset();
        start_game(pk(0, 1, 2, 3));
        submit = 1'b1;
        guess = pk(0, 6, 1, 2);
        step();
        submit = 1'b0;
        check("ill_reject", reject, 1);
        check("ill_turn", turn_num, 1);
        check("ill_busy", busy, 0);
        seen = 0;
        for (int k = 0; k < 13; k++) begin
            if (result_valid) seen++;
            step();
        end
        check("ill_no_result", seen, 0);
        check("ill_reject_drop", reject, 0);

        // Legal submit with simultaneous timeout is scored normally
        submit_guess(pk(3, 2, 1, 0), 1'b1, 0, lat);
        check("sim_latency", lat, 11);
        check("sim_timed_out", timed_out, 0);
        check("sim_black", black, 0);
        check("sim_white", white, 4);
        step();
        check("sim_turn", turn_num, 2);

        // Reset during SCORE_B aborts scoring
        submit = 1'b1;
        guess = pk(0, 1, 3, 2);
        step();
        submit = 1'b0;
        for (int k = 0; k < 6; k++) step();
        check("rsb_busy", busy, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rsb_turn", turn_num, 0);
        check("rsb_busy_clr", busy, 0);
        check("rsb_white", white, 0);
        check("rsb_outs", {next_turn, result_valid, timed_out, reject, game_over, win}, 0);
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            if (result_valid || next_turn) seen++;
            step();
        end
        check("rsb_quiet", seen, 0);

        // Timeout during SCORE_A is ignored
        start_game(pk(0, 1, 2, 3));
        submit_guess(pk(0, 1, 3, 2), 1'b0, 2, lat);
        check("tsa_latency", lat, 11);
        check("tsa_timed_out", timed_out, 0);
        check("tsa_black", black, 2);
        check("tsa_white", white, 2);
        step();
        check("tsa_turn", turn_num, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mastermind_turn_ctrl.md
# mastermind_turn_ctrl

Turn controller and guess scorer for the Mastermind game, sitting directly downstream of the per-turn countdown timer. It consumes the timer's single-cycle timeout pulse and the player's committed guess, scores each guess against the latched secret code, and counts turns toward a win or loss. It emits the single-cycle `next_turn` pulse that reloads the timer at the start of every turn.

## Interface
- `PEGS`, 4: pegs per code; peg i occupies bits [i*COLOR_W +: COLOR_W].
- `COLOR_W`, 3: bits per peg.
- `NUM_COLORS`, 6: legal colours are 0..NUM_COLORS-1.
- `MAX_TURNS`, 10: turns allowed per game.
- `clk`  in  1  system clock (50 MHz).
- `reset`  in  1  synchronous reset, active-high.
- `start`  in  1  begin or restart a game; honoured only in IDLE, WIN or LOSE.
- `secret`  in  PEGS*COLOR_W  code to break; latched on the accepted `start` cycle.
- `submit`  in  1  single-cycle guess commit.
- `guess`  in  PEGS*COLOR_W  guess; sampled on the `submit` cycle.
- `timeout`  in  1  single-cycle turn-expiry pulse from the turn timer.
- `next_turn`  out  1  one-cycle pulse on entry to PLAY; drives the timer reload.
- `turn_num`  out  4  current turn, 1..MAX_TURNS; 0 in IDLE.
- `black`, `white`  out  3 each  exact-position and colour-only match counts; hold until the next result.
- `result_valid`  out  1  one-cycle strobe; `black`, `white` and `timed_out` are valid on it.
- `timed_out`  out  1  the turn ended by timeout; held with the result.
- `reject`  out  1  one-cycle pulse: submitted guess contains an illegal colour.
- `busy`  out  1  high in SCORE and REPORT.
- `game_over`  out  1  high in WIN and LOSE.
- `win`  out  1  high in WIN.

## Operation
- States: IDLE, PLAY, SCORE_A, SCORE_B, REPORT, WIN, LOSE.
- IDLE/WIN/LOSE + `start`
  - Latch `secret`, then go to PLAY with `turn_num`=1 and `next_turn`=1.
  - Clear `black`, `white`, `timed_out`, `win` and `game_over`.
- PLAY + `submit`, all pegs < NUM_COLORS: latch `guess` and go to SCORE_A.
- PLAY + `submit`, any peg ≥ NUM_COLORS: `reject`=1 for one cycle; stay in PLAY; the turn is not consumed.
- PLAY + `timeout` without `submit`: go to REPORT with black=white=0 and `timed_out`=1.
- PLAY + `submit` and `timeout` in the same cycle: `submit` wins and `timeout` is dropped. If that guess is illegal, the cycle is treated as a timeout.
- SCORE_A (PEGS cycles, index i=0..PEGS-1)
  - If guess[i]==secret[i], increment black.
  - Increment histogram entries hg[guess[i]] and hs[secret[i]].
  - Histograms are cleared on entry.
- SCORE_B (NUM_COLORS cycles, c=0..NUM_COLORS-1): accumulate m += min(hg[c], hs[c]).
- REPORT
  - Assert `result_valid` for one cycle; `white` = m − black.
  - Next state: WIN if black==PEGS; else LOSE if `turn_num`==MAX_TURNS; else PLAY with `turn_num`+1 and `next_turn`=1.
- `timeout`, `submit` and `start` are ignored in every state not listed above.
- WIN/LOSE hold until `start` or `reset`.

## Timing
- Reset:
  - State IDLE.
  - All outputs 0.
  - Histograms and accumulators cleared.
  - Aborts any scoring in progress.
  - `next_turn` is not pulsed.
- All outputs are registered.
- Legal `submit` sampled in cycle T:
  - SCORE_A occupies T+1..T+PEGS.
  - SCORE_B occupies T+PEGS+1..T+PEGS+NUM_COLORS.
  - REPORT/`result_valid` is at R = T+PEGS+NUM_COLORS+1 (T+11 with defaults).
  - At R+1: `next_turn` pulses, `turn_num` increments, or `game_over` rises.
- `timeout` in cycle T: `result_valid` at T+1; follow-on state at T+2.
- `start` in cycle T: PLAY and `next_turn`=1 at T+1.
- `reject` rises at T+1 after an illegal `submit` at T.
- `busy` is high exactly from T+1 through R.
- `black`, `white` and `timed_out` change only in the REPORT cycle or on `start`/`reset`.

## Test plan
- Secret pegs (0,1,2,3), guess (3,2,1,0): `result_valid` at T+11 with black=0, white=4, `timed_out`=0; `next_turn` at T+12; `turn_num` goes 1→2.
- Secret (1,1,2,2), guess (1,2,1,5): black=1, white=2.
- Secret (0,1,2,3):
  - Guess (0,1,3,2) on turn 1 gives black=2, white=2.
  - Guess (0,1,2,3) on turn 2 gives black=4, white=0; WIN at R+1 with `game_over`=1, `win`=1, `turn_num`=2, and no `next_turn`.
- Ten consecutive `timeout` pulses:
  - Each gives `result_valid` with `timed_out`=1 and black=white=0.
  - After the 10th: LOSE, `turn_num`=10, `win`=0.
  - A later `start` returns to PLAY with `turn_num`=1 and one `next_turn` pulse.
- Illegal guess and simultaneous events:
  - Guess containing colour 6: `reject` pulse; `turn_num` unchanged; no `result_valid`.
  - Legal `submit` and `timeout` in the same cycle: a scored result with `timed_out`=0.
- Reset and ignored timeout:
  - `reset` asserted during SCORE_B: next cycle IDLE with all outputs 0 and no `result_valid`.
  - `timeout` during SCORE_A is ignored.
